// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: the MMIO window,
// the arbiter state encoding and the word returned on an MMIO timeout.
package mem_arbiter_pkg;

  localparam logic [31:0] MMIO_BASE    = 32'hFFFF_0000;
  localparam logic [31:0] TIMEOUT_WORD = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE,
    D_RAM,
    D_IO,
    I_RAM,
    DONE
  } state_t;

  function automatic logic is_mmio(input logic [31:0] addr);
    return addr >= MMIO_BASE;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side request bundle: fetch port, data port and the shared pipeline stall.
interface mem_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        stall;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    input  if_rdata, d_rdata, stall
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    output if_rdata, d_rdata, stall
  );

endinterface

// File: rtl/mem_arbiter_mmio_timeout.sv
// Counts consecutive MMIO wait cycles without an acknowledge; flags the cycle
// in which the limit is reached (an ack in that cycle suppresses the flag).
module mmio_timeout #(
  parameter int IO_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic ack,
  output logic expired
);

  localparam int CW = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Held at zero outside the wait state, so every new MMIO access starts fresh.
  always_comb begin
    cnt_d = '0;
    if (run && !ack) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = run && !ack && (cnt_q == CW'(IO_TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port and an MMIO bus between the data and fetch requesters,
// stalling the pipeline until both requests of a cycle have been serviced.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RAM_AW     = 12,
  parameter int IO_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      cpu,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              io_req,
  output logic              io_we,
  output logic [31:0]       io_addr,
  output logic [31:0]       io_wdata,
  input  logic [31:0]       io_rdata,
  input  logic              io_ack,
  output logic              bus_err
);

  state_t      state_q, state_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        bus_err_q, bus_err_d;
  logic        io_run, io_expired, d_exit;
  logic        unused_addr_bits;

  assign io_run = (state_q == D_IO);
  // The data access finishes this cycle; a pending fetch may use the RAM port now.
  assign d_exit = (state_q == D_RAM) || (io_run && (io_ack || io_expired));
  assign unused_addr_bits = ^{cpu.if_addr[31:RAM_AW+2], cpu.if_addr[1:0]};

  mmio_timeout #(.IO_TIMEOUT(IO_TIMEOUT)) u_mmio_timeout (
    .clk     (clk),
    .rst     (rst),
    .run     (io_run),
    .ack     (io_ack),
    .expired (io_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      d_rdata_q  <= '0;
      if_rdata_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_rdata_q  <= d_rdata_d;
      if_rdata_q <= if_rdata_d;
      bus_err_q  <= bus_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cpu.d_req)       state_d = is_mmio(cpu.d_addr) ? D_IO : D_RAM;
        else if (cpu.if_req) state_d = I_RAM;
      end
      D_RAM:   state_d = cpu.if_req ? I_RAM : DONE;
      D_IO:    if (io_ack || io_expired) state_d = cpu.if_req ? I_RAM : DONE;
      I_RAM:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu.stall  = 1'b0;
    ram_en     = 1'b0;
    ram_we     = '0;
    ram_addr   = '0;
    ram_wdata  = '0;
    io_req     = 1'b0;
    io_we      = 1'b0;
    io_addr    = '0;
    io_wdata   = '0;
    d_rdata_d  = d_rdata_q;
    if_rdata_d = if_rdata_q;
    bus_err_d  = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (cpu.d_req) begin
            cpu.stall = 1'b1;
            if (!is_mmio(cpu.d_addr)) begin
              ram_en    = 1'b1;
              ram_we    = cpu.d_we;
              ram_addr  = cpu.d_addr[RAM_AW+1:2];
              ram_wdata = cpu.d_wdata;
            end
          end else if (cpu.if_req) begin
            cpu.stall = 1'b1;
            ram_en    = 1'b1;
            ram_addr  = cpu.if_addr[RAM_AW+1:2];
          end
        end
        D_RAM: begin
          cpu.stall = 1'b1;
          d_rdata_d = ram_rdata;
        end
        D_IO: begin
          cpu.stall = 1'b1;
          io_req    = 1'b1;
          io_we     = |cpu.d_we;
          io_addr   = cpu.d_addr;
          io_wdata  = cpu.d_wdata;
          if (io_ack) begin
            d_rdata_d = io_rdata;
          end else if (io_expired) begin
            d_rdata_d = TIMEOUT_WORD;
            bus_err_d = 1'b1;
          end
        end
        I_RAM: begin
          cpu.stall  = 1'b1;
          if_rdata_d = ram_rdata;
        end
        default: ;
      endcase
      if (d_exit && cpu.if_req) begin
        ram_en   = 1'b1;
        ram_addr = cpu.if_addr[RAM_AW+1:2];
      end
    end
  end

  assign cpu.d_rdata  = d_rdata_q;
  assign cpu.if_rdata = if_rdata_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: RAM data/fetch sequencing, byte store, MMIO
// ack/timeout handling, reset in the middle of an MMIO access, and idle quiet.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        io_req;
  logic        io_we;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        io_ack;
  logic        bus_err;

  logic [31:0] mem [0:4095];

  int total;
  int bad;

  mem_arbiter_if cpu ();

  mem_arbiter #(.RAM_AW(12), .IO_TIMEOUT(255)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu       (cpu),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .io_req    (io_req),
    .io_we     (io_we),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .io_ack    (io_ack),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after ram_en; preloaded during reset.
  always @(posedge clk) begin
    if (rst) begin
      mem[0] <= 32'h2408_0005;
      mem[4] <= 32'h1122_3344;
      mem[8] <= 32'h1234_5678;
    end else if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    int n;
    logic seen_err;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    cpu.if_req  = 1'b0;
    cpu.if_addr = '0;
    cpu.d_req   = 1'b1;
    cpu.d_we    = '0;
    cpu.d_addr  = '0;
    cpu.d_wdata = '0;
    io_rdata    = '0;
    io_ack      = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_stall",    cpu.stall,    0);
    check("rst_ram_en",   ram_en,       0);
    check("rst_io_req",   io_req,       0);
    check("rst_d_rdata",  cpu.d_rdata,  0);
    check("rst_if_rdata", cpu.if_rdata, 0);
    check("rst_bus_err",  bus_err,      0);
    cpu.d_req = 1'b0;
    rst = 1'b0;
    #1;
    check("idle_stall_after_rst", cpu.stall, 0);

    // Data read plus fetch
    cpu.d_req = 1'b1; cpu.d_we = 4'h0; cpu.d_addr = 32'h10;
    cpu.if_req = 1'b1; cpu.if_addr = 32'h0;
    #1;
    check("t1_idle_stall",    cpu.stall, 1);
    check("t1_idle_ram_en",   ram_en,    1);
    check("t1_idle_ram_addr", ram_addr,  4);
    tick();
    check("t1_dram_stall",    cpu.stall, 1);
    check("t1_fetch_en",      ram_en,    1);
    check("t1_fetch_addr",    ram_addr,  0);
    tick();
    check("t1_iram_stall",    cpu.stall, 1);
    tick();
    check("t1_done_stall",    cpu.stall,    0);
    check("t1_d_rdata",       cpu.d_rdata,  32'h1122_3344);
    check("t1_if_rdata",      cpu.if_rdata, 32'h2408_0005);
    cpu.d_req = 1'b0; cpu.if_req = 1'b0;
    tick();
    check("t1_back_idle",     cpu.stall, 0);

    // Byte store, then read back the merged word
    cpu.d_req = 1'b1; cpu.d_we = 4'b0100; cpu.d_wdata = 32'h00AB_0000; cpu.d_addr = 32'h22;
    #1;
    check("t2_ram_we",    ram_we,    4'b0100);
    check("t2_ram_addr",  ram_addr,  8);
    check("t2_ram_wdata", ram_wdata, 32'h00AB_0000);
    check("t2_idle_stall", cpu.stall, 1);
    tick();
    check("t2_dram_stall", cpu.stall, 1);
    check("t2_dram_no_en", ram_en,    0);
    tick();
    check("t2_done_stall", cpu.stall, 0);
    cpu.d_req = 1'b0; cpu.d_we = 4'h0;
    tick();
    cpu.d_req = 1'b1; cpu.d_addr = 32'h20;
    tick();
    tick();
    check("t2_readback", cpu.d_rdata, 32'h12AB_5678);
    cpu.d_req = 1'b0;
    tick();

    // MMIO read acked on the third wait cycle
    cpu.d_req = 1'b1; cpu.d_addr = 32'hFFFF_0004;
    #1;
    check("t3_idle_io_req", io_req, 0);
    check("t3_idle_ram_en", ram_en, 0);
    tick();
    check("t3_io1_req",  io_req,  1);
    check("t3_io1_addr", io_addr, 32'hFFFF_0004);
    check("t3_io1_we",   io_we,   0);
    tick();
    check("t3_io2_req",  io_req,  1);
    tick();
    io_ack = 1'b1; io_rdata = 32'h5A;
    #1;
    check("t3_io3_req",  io_req,  1);
    tick();
    io_ack = 1'b0; io_rdata = '0;
    #1;
    check("t3_done_io_req", io_req,      0);
    check("t3_done_stall",  cpu.stall,   0);
    check("t3_d_rdata",     cpu.d_rdata, 32'h5A);
    check("t3_bus_err",     bus_err,     0);
    cpu.d_req = 1'b0;
    tick();

    // MMIO write acked at once, followed by a fetch
    cpu.d_req = 1'b1; cpu.d_we = 4'hF; cpu.d_addr = 32'hFFFF_0010; cpu.d_wdata = 32'hCAFE_F00D;
    cpu.if_req = 1'b1; cpu.if_addr = 32'h10;
    tick();
    io_ack = 1'b1;
    #1;
    check("t4_io_we",     io_we,    1);
    check("t4_io_wdata",  io_wdata, 32'hCAFE_F00D);
    check("t4_fetch_en",  ram_en,   1);
    check("t4_fetch_addr", ram_addr, 4);
    tick();
    io_ack = 1'b0;
    #1;
    check("t4_iram_stall",  cpu.stall, 1);
    check("t4_iram_io_req", io_req,    0);
    tick();
    check("t4_done_stall",  cpu.stall,    0);
    check("t4_if_rdata",    cpu.if_rdata, 32'h1122_3344);
    cpu.d_req = 1'b0; cpu.if_req = 1'b0; cpu.d_we = 4'h0;
    tick();

    // MMIO timeout with no ack at all
    cpu.d_req = 1'b1; cpu.d_addr = 32'hFFFF_0008;
    tick();
    n = 0;
    seen_err = 1'b0;
    while (io_req && n < 400) begin
      n++;
      if (bus_err) seen_err = 1'b1;
      tick();
    end
    check("t5_wait_cycles", n,           255);
    check("t5_no_early_err", seen_err,   0);
    check("t5_bus_err",     bus_err,     1);
    check("t5_d_rdata",     cpu.d_rdata, 32'hDEAD_BEEF);
    check("t5_done_stall",  cpu.stall,   0);
    cpu.d_req = 1'b0;
    tick();
    check("t5_err_pulse_end", bus_err, 0);

    // Ack arriving in the very cycle the timeout would fire
    cpu.d_req = 1'b1; cpu.d_addr = 32'hFFFF_000C;
    tick();
    repeat (254) tick();
    check("t6_still_waiting", io_req, 1);
    io_ack = 1'b1; io_rdata = 32'h77;
    tick();
    io_ack = 1'b0; io_rdata = '0;
    #1;
    check("t6_bus_err",    bus_err,     0);
    check("t6_d_rdata",    cpu.d_rdata, 32'h77);
    check("t6_done_stall", cpu.stall,   0);
    cpu.d_req = 1'b0;
    tick();

    // Reset in the second MMIO wait cycle
    cpu.d_req = 1'b1; cpu.d_addr = 32'hFFFF_0004;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("t7_io_req",  io_req,      0);
    check("t7_stall",   cpu.stall,   0);
    check("t7_d_rdata", cpu.d_rdata, 0);
    check("t7_bus_err", bus_err,     0);
    cpu.d_req = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("t7_if_rdata", cpu.if_rdata, 0);

    // Ten idle cycles
    for (int i = 0; i < 10; i++) begin
      check("t8_idle_quiet", {29'd0, cpu.stall, ram_en, io_req}, 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: RAM_AW, 12, RAM word-address width.
REQ-002 Parameter: IO_TIMEOUT, 255, MMIO cycles without io_ack before forced completion.
REQ-003 Reset rst, asynchronous, active-high; clock clk.
REQ-004 clk  in  1  clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 if_req  in  1  fetch request; if_addr  in  32  fetch byte address; if_rdata  out  32  fetched word.
REQ-007 d_req  in  1  data request; d_we  in  4  byte-lane write enables (0 = read); d_addr  in  32  byte address; d_wdata  in  32  lane-aligned write data; d_rdata  out  32  read word.
REQ-008 stall  out  1  freezes all pipeline stages while high.
REQ-009 ram_en  out  1; ram_we  out  4; ram_addr  out  RAM_AW; ram_wdata  out  32; ram_rdata  in  32 (data valid the cycle after ram_en).
REQ-010 io_req  out  1; io_we  out  1; io_addr  out  32; io_wdata  out  32; io_rdata  in  32; io_ack  in  1.
REQ-011 bus_err  out  1  one-cycle pulse on MMIO timeout.

Function
REQ-012 Requesters hold all request inputs stable while stall is high.
REQ-013 MMIO region: d_addr >= MMIO_BASE (0xFFFF0000). All other data accesses, and all fetches regardless of address, go to RAM.
REQ-014 ram_addr = address[RAM_AW+1:2]. Upper bits are ignored; no wrap check.
REQ-015 FSM states: IDLE, D_RAM, D_IO, I_RAM, DONE.
REQ-016 IDLE, no requests: stall=0, ram_en=0, io_req=0; stay in IDLE.
REQ-017 IDLE with d_req: stall=1.
  - RAM target: drive ram_en=1, ram_we=d_we, ram_wdata=d_wdata; next state D_RAM.
  - MMIO target: next state D_IO.
REQ-018 IDLE with if_req only: stall=1; drive ram_en=1, ram_we=0; next state I_RAM.
REQ-019 D_RAM: stall=1; capture ram_rdata into d_rdata (writes also capture it).
  - If if_req: issue the fetch read this cycle; next state I_RAM.
  - Otherwise: next state DONE.
REQ-020 D_IO: stall=1.
  - Drive io_req=1, io_we=|d_we, io_addr=d_addr, io_wdata=d_wdata.
  - On io_ack: capture io_rdata into d_rdata; leave exactly as D_RAM does (REQ-019).
REQ-021 D_IO timeout: a counter cleared on D_IO entry counts D_IO cycles without io_ack.
  - After IO_TIMEOUT such cycles: d_rdata=0xDEADBEEF, bus_err pulse, exit as in REQ-020.
  - io_ack in the same cycle as timeout: the ack wins and bus_err is not asserted.
REQ-022 I_RAM: stall=1; capture ram_rdata into if_rdata; next state DONE.
REQ-023 DONE: stall=0; io_req=0; ram_en=0; next state IDLE.
REQ-024 Latency:
  - RAM data+fetch: 3 cycles with stall.
  - Single RAM access: 2 cycles with stall.
  - MMIO: wait cycles + 1, plus 1 if a fetch follows.
  - Each case is followed by one DONE cycle.
REQ-025 Data always has priority over fetch; only one RAM access is issued per cycle.
REQ-026 if_rdata and d_rdata are registered and hold their value until recaptured.
REQ-027 io_req deasserts the cycle after io_ack is sampled.

Reset
REQ-028 Reset forces IDLE, clears the timeout counter, and zeroes if_rdata, d_rdata and bus_err; ram_en, io_req and stall are 0 while rst is high.
REQ-029 Reset mid-access (any state) abandons the access: io_req drops immediately and no capture occurs.

Structure
REQ-030 Shared package holds MMIO_BASE, the state enum type and the timeout sentinel 0xDEADBEEF.
REQ-031 Single module; the MMIO timeout counter may be a sub-module named mmio_timeout.

Verification
REQ-032 Data read plus fetch: d_req=1, d_we=0, d_addr=0x10, RAM[4]=0x11223344, if_addr=0x0, RAM[0]=0x24080005.
  - Required: stall high for 3 cycles.
  - In DONE: d_rdata=0x11223344, if_rdata=0x24080005.
REQ-033 Byte store: d_we=4'b0100, d_wdata=0x00AB0000, d_addr=0x22.
  - Required: ram_we=0100 and ram_addr=8 in the IDLE cycle; stall released after D_RAM.
REQ-034 MMIO read: d_addr=0xFFFF0004, io_ack after 3 cycles with io_rdata=0x5A.
  - Required: io_req held 3 cycles; d_rdata=0x5A; bus_err=0.
REQ-035 MMIO timeout: io_ack never asserted.
  - Required: after 255 D_IO cycles, d_rdata=0xDEADBEEF and a single bus_err pulse; FSM reaches DONE.
REQ-036 Reset in D_IO: rst asserted in the 2nd D_IO cycle.
  - Required: io_req=0 and stall=0 immediately; IDLE after release; outputs zero.
REQ-037 Idle: no requests for 10 cycles.
  - Required: stall=0, ram_en=0, io_req=0 throughout.
